// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio subsystem (capture and playback paths).
//   AUDIO_SAMPLE_W  : default sample width of the audio datapath
//   I2S_MAX_BITS    : longest legal I2S word; longer words are framing errors
//   i2s_state_t     : receiver framing state
//   stereo_sample_t : one left/right pair, fields sized for the widest sample
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int AUDIO_SAMPLE_W = 24;
    localparam int I2S_MAX_BITS   = 32;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } i2s_state_t;

    typedef struct packed {
        logic [I2S_MAX_BITS-1:0] left;
        logic [I2S_MAX_BITS-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/adcif_sync.sv
// -----------------------------------------------------------------------------
// adcif_sync
// Brings the asynchronous I2S pins into the clk domain. BCK goes through an
// N-stage synchronizer followed by a rise detector; LRCK and DATA go through
// identical stages plus one matching register so that, in the cycle bck_rise
// is high, lrck_s/data_s hold the pin values seen at that BCK rise.
// Ports:
//   clk, rst        : system clock, async active-high reset
//   i2s_bck/lrck/data : raw I2S pins (asynchronous)
//   bck_rise        : one-cycle pulse per BCK rising edge
//   lrck_s, data_s  : synchronized LRCK and DATA, aligned with bck_rise
// -----------------------------------------------------------------------------
module adcif_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i2s_bck,
    input  logic i2s_lrck,
    input  logic i2s_data,
    output logic bck_rise,
    output logic lrck_s,
    output logic data_s
);

    logic [SYNC_STAGES-1:0] bck_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   bck_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchronizer chain into a single stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bck_sync  <= '0;
            lrck_sync <= '0;
            data_sync <= '0;
            bck_d     <= 1'b0;
            bck_rise  <= 1'b0;
            lrck_s    <= 1'b0;
            data_s    <= 1'b0;
        end else begin
            bck_sync  <= {bck_sync[SYNC_STAGES-2:0], i2s_bck};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
            data_sync <= {data_sync[SYNC_STAGES-2:0], i2s_data};
            bck_d     <= bck_sync[SYNC_STAGES-1];
            bck_rise  <= bck_sync[SYNC_STAGES-1] & ~bck_d;
            // Registered once more to stay aligned with the registered rise.
            lrck_s    <= lrck_sync[SYNC_STAGES-1];
            data_s    <= data_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/adcif.sv
// -----------------------------------------------------------------------------
// adcif
// I2S slave receiver: deserializes a Philips I2S stereo stream (one-BCK data
// delay, MSB first) into parallel left/right samples, one pair per LRCK frame.
// Configuration macro: ADCIF_FIFO_EN
//   undefined : single output register, sample_valid is a one-cycle pulse,
//               no sample_ready port, overrun tied low
//   defined   : FIFO_DEPTH-entry first-word-fall-through pair FIFO,
//               sample_valid = non-empty, pop on sample_valid && sample_ready
// Ports:
//   clk, rst       : system clock (>= 4x BCK), async active-high reset
//   enable         : receiver enable; low drops back to SYNC_WAIT
//   i2s_bck/lrck/data : I2S pins from the external ADC (asynchronous)
//   left_data, right_data : received pair (two's complement, left-justified)
//   sample_valid   : pair available
//   sample_ready   : pop strobe (FIFO build only)
//   overrun        : one-cycle pulse when a completed pair is dropped
//   frame_err      : one-cycle pulse when a word exceeds I2S_MAX_BITS
// -----------------------------------------------------------------------------
module adcif
    import audio_pkg::*;
#(
    parameter int SAMPLE_W    = AUDIO_SAMPLE_W,
    parameter int SYNC_STAGES = 2
`ifdef ADCIF_FIFO_EN
    ,
    parameter int FIFO_DEPTH  = 4
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                i2s_bck,
    input  logic                i2s_lrck,
    input  logic                i2s_data,
    output logic [SAMPLE_W-1:0] left_data,
    output logic [SAMPLE_W-1:0] right_data,
    output logic                sample_valid,
`ifdef ADCIF_FIFO_EN
    input  logic                sample_ready,
`endif
    output logic                overrun,
    output logic                frame_err
);

    localparam logic [5:0] WORD_BITS = 6'(SAMPLE_W);
    localparam logic [5:0] MSB_POS   = 6'(SAMPLE_W - 1);
    localparam logic [5:0] MAX_BITS  = 6'(I2S_MAX_BITS);

    logic                bck_rise;
    logic                lrck_s;
    logic                data_s;

    logic                lrck_prev;
    logic [5:0]          bit_cnt;
    logic [SAMPLE_W-1:0] shift_reg;
    logic [SAMPLE_W-1:0] left_hold;
    i2s_state_t          state;

    logic                boundary;
    logic [SAMPLE_W-1:0] word_next;
    logic [5:0]          cnt_next;
    logic                too_long;
    i2s_state_t          state_next;
    logic                latch_left;
    logic                commit;
    logic                err_next;

    adcif_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .i2s_bck  (i2s_bck),
        .i2s_lrck (i2s_lrck),
        .i2s_data (i2s_data),
        .bck_rise (bck_rise),
        .lrck_s   (lrck_s),
        .data_s   (data_s)
    );

    // The bit sampled at a rise belongs to channel lrck_prev; an LRCK change
    // means this bit is the LSB of the word that is finishing.
    assign boundary = (lrck_s != lrck_prev);
    assign cnt_next = (bit_cnt == 6'd63) ? 6'd63 : bit_cnt + 6'd1;
    assign too_long = (cnt_next > MAX_BITS);

    // Each bit lands directly at its left-justified position, so short words
    // come out with zero LSBs and bits past SAMPLE_W are simply not stored.
    always_comb begin
        word_next = shift_reg;
        if (bit_cnt < WORD_BITS) begin
            word_next = shift_reg |
                        ({{(SAMPLE_W-1){1'b0}}, data_s} << (MSB_POS - bit_cnt));
        end
    end

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        latch_left = 1'b0;
        commit     = 1'b0;
        err_next   = 1'b0;
        if (!enable) begin
            state_next = SYNC_WAIT;
        end else if (bck_rise) begin
            case (state)
                SYNC_WAIT: begin
                    // Only a falling LRCK starts a frame; the partial word
                    // that just closed is thrown away.
                    if (boundary && !lrck_s) begin
                        state_next = LEFT;
                    end
                end
                LEFT: begin
                    if (boundary) begin
                        state_next = RIGHT;
                        latch_left = 1'b1;
                    end else if (too_long) begin
                        state_next = SYNC_WAIT;
                        err_next   = 1'b1;
                    end
                end
                RIGHT: begin
                    if (boundary) begin
                        state_next = LEFT;
                        commit     = 1'b1;
                    end else if (too_long) begin
                        state_next = SYNC_WAIT;
                        err_next   = 1'b1;
                    end
                end
                default: state_next = SYNC_WAIT;
            endcase
        end
    end

    // The word datapath keeps tracking LRCK while disabled so that framing
    // resumes cleanly on the first boundary after enable returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SYNC_WAIT;
            lrck_prev <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            left_hold <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            frame_err <= err_next;
            if (bck_rise) begin
                lrck_prev <= lrck_s;
                if (boundary) begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end else begin
                    shift_reg <= word_next;
                    bit_cnt   <= cnt_next;
                end
            end
            if (latch_left) begin
                left_hold <= word_next;
            end
        end
    end

`ifdef ADCIF_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    stereo_sample_t fifo_mem [FIFO_DEPTH];
    stereo_sample_t pair_in;
    stereo_sample_t head;
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           empty;
    logic           full;
    logic           pop;
    logic           push;

    assign pair_in = {I2S_MAX_BITS'(left_hold), I2S_MAX_BITS'(word_next)};
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && sample_ready;
    // A pop in the same cycle frees the slot the push writes into.
    assign push    = commit && (!full || pop);
    assign head    = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= commit && !push;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving the array unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= pair_in;
        end
    end

    // Gate the head so the outputs read zero while nothing is stored.
    assign sample_valid = !empty;
    assign left_data    = empty ? '0 : SAMPLE_W'(head.left);
    assign right_data   = empty ? '0 : SAMPLE_W'(head.right);
`else
    assign overrun = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= commit;
            if (commit) begin
                left_data  <= left_hold;
                right_data <= word_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adcif.sv
// -----------------------------------------------------------------------------
// tb_adcif
// Directed bench for adcif. The bench acts as the I2S master (BCK = clk/8)
// and records every delivered pair from the output side. Builds with or
// without ADCIF_FIFO_EN; the FIFO sequence runs only in the FIFO build.
// -----------------------------------------------------------------------------
module tb_adcif;

    localparam int SW = 24;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          enable   = 1'b0;
    logic          i2s_bck  = 1'b0;
    logic          i2s_lrck = 1'b1;
    logic          i2s_data = 1'b0;
    logic [SW-1:0] left_data;
    logic [SW-1:0] right_data;
    logic          sample_valid;
    logic          overrun;
    logic          frame_err;
`ifdef ADCIF_FIFO_EN
    logic          sample_ready = 1'b1;
    wire           mon_ready = sample_ready;
`else
    wire           mon_ready = 1'b1;
`endif

    adcif #(
        .SAMPLE_W    (SW),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .i2s_bck      (i2s_bck),
        .i2s_lrck     (i2s_lrck),
        .i2s_data     (i2s_data),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
`ifdef ADCIF_FIFO_EN
        .sample_ready (sample_ready),
`endif
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
    } pair_t;

    typedef struct {
        int            n;
        logic [31:0]   tx_l;
        logic [31:0]   tx_r;
        logic [SW-1:0] exp_l;
        logic [SW-1:0] exp_r;
    } vec_t;

    vec_t  vecs [6];
    pair_t got_q [$];
    int    err_cycles = 0;
    int    ovr_cycles = 0;
    int    n_pass = 0;
    int    n_total = 0;
    logic  carry = 1'b0;

    // Output monitor: one record per delivered (and, with a FIFO, popped) pair.
    always @(negedge clk) begin
        if (!rst) begin
            if (sample_valid && mon_ready) got_q.push_back({left_data, right_data});
            if (frame_err) err_cycles++;
            if (overrun) ovr_cycles++;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic expect_pair(input string name, input int idx,
                               input logic [SW-1:0] el, input logic [SW-1:0] er);
        pair_t p = '0;
        if (idx < got_q.size()) p = got_q[idx];
        check({name, "_left"}, 64'(p.l), 64'(el));
        check({name, "_right"}, 64'(p.r), 64'(er));
    endtask

    // One BCK period: LRCK/DATA change while BCK is low, receiver samples on rise.
    task automatic send_bit(input logic lr, input logic d);
        i2s_bck  = 1'b0;
        i2s_lrck = lr;
        i2s_data = d;
        #40;
        i2s_bck  = 1'b1;
        #40;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #25;
        check("rst_mid_valid", 64'(sample_valid), 64'd0);
        check("rst_mid_left", 64'(left_data), 64'd0);
        rst = 1'b0;
        #5;
    endtask

    // Philips framing: every slot carries the bit queued in the previous slot,
    // so the LSB of each word is sent in the first slot of the other channel.
    // evt 1: drop enable for 3 BCK mid-left; evt 2: reset pulse mid-left.
    task automatic send_frame(input int n, input logic [31:0] l, input logic [31:0] r,
                              input int evt);
        for (int k = 0; k < n; k++) begin
            if (evt == 1 && k == 8)  enable = 1'b0;
            if (evt == 1 && k == 11) enable = 1'b1;
            if (evt == 2 && k == 8)  pulse_rst();
            send_bit(1'b0, carry);
            carry = l[n-1-k];
        end
        for (int k = 0; k < n; k++) begin
            send_bit(1'b1, carry);
            carry = r[n-1-k];
        end
    endtask

    // First slot of the next left word: delivers the last right LSB.
    task automatic close_frame();
        send_bit(1'b0, carry);
        carry = 1'b0;
        #200;
    endtask

    initial begin
        int base;
        int e0;

        vecs[0] = '{32, 32'h12345600, 32'hABCDEF00, 24'h123456, 24'hABCDEF};
        vecs[1] = '{32, 32'h12345600, 32'hABCDEF00, 24'h123456, 24'hABCDEF};
        vecs[2] = '{16, 32'h0000A5A5, 32'h00008001, 24'hA5A500, 24'h800100};
        vecs[3] = '{24, 32'h007FFFFF, 32'h00800000, 24'h7FFFFF, 24'h800000};
        vecs[4] = '{8,  32'h00000080, 32'h0000007F, 24'h800000, 24'h7F0000};
        vecs[5] = '{32, 32'h123456FF, 32'h000000AA, 24'h123456, 24'h000000};

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        check("reset_valid", 64'(sample_valid), 64'd0);
        check("reset_left", 64'(left_data), 64'd0);
        check("reset_right", 64'(right_data), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);
        rst    = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);

        // Stream starts mid-right-word, then the vector table back to back
        base = got_q.size();
        repeat (5) send_bit(1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 6; i++) send_frame(vecs[i].n, vecs[i].tx_l, vecs[i].tx_r, 0);
        close_frame();
        check("table_pairs", 64'(got_q.size() - base), 64'd6);
        for (int i = 0; i < 6; i++)
            expect_pair($sformatf("vec%0d", i), base + i, vecs[i].exp_l, vecs[i].exp_r);
`ifndef ADCIF_FIFO_EN
        check("hold_left", 64'(left_data), 64'(vecs[5].exp_l));
        check("hold_right", 64'(right_data), 64'(vecs[5].exp_r));
`endif

        // Over-long word: 40 BCK with LRCK low
        base = got_q.size();
        e0   = err_cycles;
        repeat (39) send_bit(1'b0, 1'($urandom_range(0, 1)));
        repeat (4) send_bit(1'b1, 1'($urandom_range(0, 1)));
        send_frame(24, 32'h0013579B, 32'h00FDB975, 0);
        close_frame();
        check("frame_err_cycles", 64'(err_cycles - e0), 64'd1);
        check("err_recover_pairs", 64'(got_q.size() - base), 64'd1);
        expect_pair("err_recover", base, 24'h13579B, 24'hFDB975);

        // Enable dropped mid-left for 3 BCK
        base = got_q.size();
        send_frame(32, 32'hDEADBE00, 32'h0BADF000, 1);
        send_frame(16, 32'h00001234, 32'h0000FEDC, 0);
        close_frame();
        check("enable_drop_pairs", 64'(got_q.size() - base), 64'd1);
        expect_pair("enable_drop", base, 24'h123400, 24'hFEDC00);

        // Reset pulsed mid-left
        base = got_q.size();
        send_frame(32, 32'h55555500, 32'hAAAAAA00, 2);
        send_frame(24, 32'h00C0FFEE, 32'h00F00D42, 0);
        close_frame();
        check("rst_mid_pairs", 64'(got_q.size() - base), 64'd1);
        expect_pair("rst_mid", base, 24'hC0FFEE, 24'hF00D42);

`ifdef ADCIF_FIFO_EN
        // FIFO fill without popping: 5 frames into 4 entries
        sample_ready = 1'b0;
        enable       = 1'b0;
        repeat (4) send_bit(1'b1, 1'($urandom_range(0, 1)));
        enable = 1'b1;
        e0     = ovr_cycles;
        for (int i = 1; i < 6; i++) send_frame(vecs[i].n, vecs[i].tx_l, vecs[i].tx_r, 0);
        close_frame();
        check("fifo_overrun_cycles", 64'(ovr_cycles - e0), 64'd1);
        check("fifo_valid_full", 64'(sample_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("fifo_pop%0d_left", i), 64'(left_data), 64'(vecs[i+1].exp_l));
            check($sformatf("fifo_pop%0d_right", i), 64'(right_data), 64'(vecs[i+1].exp_r));
            sample_ready = 1'b1;
            @(negedge clk);
            sample_ready = 1'b0;
        end
        #1;
        check("fifo_valid_empty", 64'(sample_valid), 64'd0);
`else
        check("overrun_never", 64'(ovr_cycles), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
